// File: rtl/vend_if.sv
// vend_if -- customer/mechanism signals of the vending controller.
//   Inputs to the controller: rupee_one, rupee_two, sel_valid, sel_item,
//     cancel, disp_done, change_ack.
//   Outputs from the controller: dispense_req, item_out, change_req,
//     credit, coin_reject, sel_short, fault, state.
//   master: the environment (coin acceptor, keypad, dispenser, hopper).
//   slave : the controller.
interface vend_if;
    logic       rupee_one;
    logic       rupee_two;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       disp_done;
    logic       change_ack;
    logic       dispense_req;
    logic [1:0] item_out;
    logic       change_req;
    logic [3:0] credit;
    logic       coin_reject;
    logic       sel_short;
    logic       fault;
    logic [2:0] state;

    modport master (
        output rupee_one, rupee_two, sel_valid, sel_item, cancel, disp_done, change_ack,
        input  dispense_req, item_out, change_req, credit, coin_reject, sel_short, fault, state
    );

    modport slave (
        input  rupee_one, rupee_two, sel_valid, sel_item, cancel, disp_done, change_ack,
        output dispense_req, item_out, change_req, credit, coin_reject, sel_short, fault, state
    );
endinterface

// File: rtl/vend_controller.sv
// vend_controller -- four-item vending machine controller.
//   clk   : single clock, rising edge.
//   reset : synchronous, active-high.
//   bus   : vend_if.slave (coin/selection/cancel strobes in; dispense,
//           change, credit and status out). All outputs are registered.
//
//   state  | meaning
//   IDLE   | no credit, accepting coins
//   CREDIT | credit > 0, accepting coins / selection / cancel
//   VEND   | dispense_req held, waiting for disp_done or timeout
//   CHANGE | returning credit one rupee per acknowledged change_req
module vend_controller #(
    parameter int PRICE0       = 5,
    parameter int PRICE1       = 3,
    parameter int PRICE2       = 4,
    parameter int PRICE3       = 7,
    parameter int MAX_CREDIT   = 9,
    parameter int DISP_TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  reset,
    vend_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_CREDIT = 3'b001,
        S_VEND   = 3'b010,
        S_CHANGE = 3'b011
    } state_t;

    localparam logic [4:0] MAX_C    = 5'(MAX_CREDIT);
    localparam logic [7:0] CNT_LAST = 8'(DISP_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [1:0] item_q, item_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dreq_q, dreq_d;
    logic       creq_q, creq_d;
    logic       rej_q, rej_d;
    logic       short_q, short_d;
    logic       fault_q, fault_d;
    logic [4:0] acc;
    logic [3:0] sel_price;
    logic       coin_any;

    function automatic logic [3:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    price_of = 4'(PRICE0);
            2'd1:    price_of = 4'(PRICE1);
            2'd2:    price_of = 4'(PRICE2);
            default: price_of = 4'(PRICE3);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            item_q   <= '0;
            cnt_q    <= '0;
            dreq_q   <= 1'b0;
            creq_q   <= 1'b0;
            rej_q    <= 1'b0;
            short_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            cnt_q    <= cnt_d;
            dreq_q   <= dreq_d;
            creq_q   <= creq_d;
            rej_q    <= rej_d;
            short_q  <= short_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        item_d    = item_q;
        cnt_d     = cnt_q;
        rej_d     = 1'b0;
        short_d   = 1'b0;
        fault_d   = 1'b0;
        acc       = {1'b0, credit_q};
        coin_any  = bus.rupee_one | bus.rupee_two;
        sel_price = price_of(bus.sel_item);

        case (state_q)
            S_IDLE, S_CREDIT: begin
                // cancel with nothing to refund is a no-op; lower priorities still apply
                if (bus.cancel && state_q == S_CREDIT) begin
                    state_d = S_CHANGE;
                    rej_d   = coin_any;
                end else if (bus.sel_valid) begin
                    rej_d = coin_any;
                    if (credit_q >= sel_price) begin
                        credit_d = credit_q - sel_price;
                        item_d   = bus.sel_item;
                        cnt_d    = '0;
                        state_d  = S_VEND;
                    end else begin
                        short_d = 1'b1;
                    end
                end else begin
                    // rupee_two is taken first; a simultaneous rupee_one is always refused
                    if (bus.rupee_two) begin
                        if (acc + 5'd2 <= MAX_C) acc = acc + 5'd2;
                        else                     rej_d = 1'b1;
                    end
                    if (bus.rupee_one) begin
                        if (bus.rupee_two || (acc + 5'd1 > MAX_C)) rej_d = 1'b1;
                        else                                       acc   = acc + 5'd1;
                    end
                    credit_d = acc[3:0];
                    state_d  = (acc == 5'd0) ? S_IDLE : S_CREDIT;
                end
            end
            S_VEND: begin
                rej_d = coin_any;
                if (bus.disp_done) begin
                    state_d = (credit_q != 4'd0) ? S_CHANGE : S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // refund the undelivered item and hand everything back
                    fault_d  = 1'b1;
                    credit_d = credit_q + price_of(item_q);
                    state_d  = S_CHANGE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CHANGE: begin
                rej_d = coin_any;
                if (credit_q == 4'd0) begin
                    state_d = S_IDLE;
                end else if (creq_q && bus.change_ack) begin
                    credit_d = credit_q - 4'd1;
                    if (credit_q == 4'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        dreq_d = (state_d == S_VEND);
        creq_d = (state_d == S_CHANGE) && (credit_d != 4'd0);
    end

    assign bus.dispense_req = dreq_q;
    assign bus.item_out     = item_q;
    assign bus.change_req   = creq_q;
    assign bus.credit       = credit_q;
    assign bus.coin_reject  = rej_q;
    assign bus.sel_short    = short_q;
    assign bus.fault        = fault_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_vend_controller.sv
module tb_vend_controller;
    localparam int MAXC = 9;
    localparam int TMO  = 16;
    localparam int ST_IDLE = 0, ST_CREDIT = 1, ST_VEND = 2, ST_CHANGE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    vend_if bus ();

    vend_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int price[4] = '{5, 3, 4, 7};

    // reference model: machine described as credit + mode + elapsed vend cycles
    int m_state, m_credit, m_item, m_vend_cycles;
    bit m_dreq, m_creq, m_rej, m_short, m_fault;
    bit m_valid = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit r1, r2;
        r1 = bus.rupee_one;
        r2 = bus.rupee_two;
        m_rej = 0; m_short = 0; m_fault = 0;
        if (m_state == ST_IDLE || m_state == ST_CREDIT) begin
            if (bus.cancel && m_credit > 0) begin
                m_state = ST_CHANGE;
                m_rej = r1 | r2;
            end else if (bus.sel_valid) begin
                m_rej = r1 | r2;
                if (m_credit >= price[bus.sel_item]) begin
                    m_credit -= price[bus.sel_item];
                    m_item = bus.sel_item;
                    m_vend_cycles = 0;
                    m_state = ST_VEND;
                end else m_short = 1;
            end else begin
                if (r2) begin
                    if (m_credit + 2 <= MAXC) m_credit += 2; else m_rej = 1;
                end
                if (r1) begin
                    if (r2 || m_credit + 1 > MAXC) m_rej = 1; else m_credit += 1;
                end
                m_state = (m_credit > 0) ? ST_CREDIT : ST_IDLE;
            end
        end else if (m_state == ST_VEND) begin
            m_rej = r1 | r2;
            if (bus.disp_done) m_state = (m_credit > 0) ? ST_CHANGE : ST_IDLE;
            else if (m_vend_cycles == TMO - 1) begin
                m_fault = 1;
                m_credit += price[m_item];
                m_state = ST_CHANGE;
            end else m_vend_cycles++;
        end else begin
            m_rej = r1 | r2;
            if (m_creq && bus.change_ack) begin
                m_credit -= 1;
                if (m_credit == 0) m_state = ST_IDLE;
            end
        end
        m_dreq = (m_state == ST_VEND);
        m_creq = (m_state == ST_CHANGE) && (m_credit > 0);
    endtask

    always begin
        @(posedge clk);
        if (reset) begin
            m_state = ST_IDLE; m_credit = 0; m_item = 0; m_vend_cycles = 0;
            m_dreq = 0; m_creq = 0; m_rej = 0; m_short = 0; m_fault = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            model_step();
        end
        #1;
        if (m_valid) begin
            chk("state", int'(bus.state), m_state);
            chk("credit", int'(bus.credit), m_credit);
            chk("item_out", int'(bus.item_out), m_item);
            chk("dispense_req", int'(bus.dispense_req), int'(m_dreq));
            chk("change_req", int'(bus.change_req), int'(m_creq));
            chk("coin_reject", int'(bus.coin_reject), int'(m_rej));
            chk("sel_short", int'(bus.sel_short), int'(m_short));
            chk("fault", int'(bus.fault), int'(m_fault));
        end
    end

    task automatic cyc(input bit r1, input bit r2, input bit sv, input logic [1:0] it,
                       input bit cn, input bit dd, input bit ack, input bit rst);
        @(negedge clk);
        bus.rupee_one = r1; bus.rupee_two = r2; bus.sel_valid = sv; bus.sel_item = it;
        bus.cancel = cn; bus.disp_done = dd; bus.change_ack = ack; reset = rst;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();           cyc(0, 0, 0, 2'd0, 0, 0, 0, 0); endtask
    task automatic rst();            cyc(0, 0, 0, 2'd0, 0, 0, 0, 1); endtask
    task automatic c1();             cyc(1, 0, 0, 2'd0, 0, 0, 0, 0); endtask
    task automatic c2();             cyc(0, 1, 0, 2'd0, 0, 0, 0, 0); endtask
    task automatic sel(input logic [1:0] it); cyc(0, 0, 1, it, 0, 0, 0, 0); endtask
    task automatic done();           cyc(0, 0, 0, 2'd0, 0, 1, 0, 0); endtask
    task automatic ack();            cyc(0, 0, 0, 2'd0, 0, 0, 1, 0); endtask

    initial begin
        bus.rupee_one = 0; bus.rupee_two = 0; bus.sel_valid = 0; bus.sel_item = 0;
        bus.cancel = 0; bus.disp_done = 0; bus.change_ack = 0;

        // reset state
        rst();
        chk("lit_rst_state", int'(bus.state), 0);
        chk("lit_rst_credit", int'(bus.credit), 0);

        // two, two, one, buy item 0
        c2(); chk("lit_a_credit2", int'(bus.credit), 2);
        c2(); chk("lit_a_credit4", int'(bus.credit), 4);
        c1(); chk("lit_a_credit5", int'(bus.credit), 5);
        sel(2'd0);
        chk("lit_a_dreq", int'(bus.dispense_req), 1);
        chk("lit_a_item", int'(bus.item_out), 0);
        chk("lit_a_credit0", int'(bus.credit), 0);
        done();
        chk("lit_a_idle", int'(bus.state), 0);
        chk("lit_a_dreq_low", int'(bus.dispense_req), 0);

        // credit 7, buy item 1, take change
        rst(); c2(); c2(); c2(); c1();
        chk("lit_b_credit7", int'(bus.credit), 7);
        sel(2'd1);
        chk("lit_b_vend", int'(bus.state), 2);
        chk("lit_b_credit4", int'(bus.credit), 4);
        done();
        chk("lit_b_change", int'(bus.state), 3);
        chk("lit_b_creq", int'(bus.change_req), 1);
        for (int i = 3; i >= 0; i--) begin
            ack();
            chk("lit_b_credit_dec", int'(bus.credit), i);
        end
        chk("lit_b_idle", int'(bus.state), 0);
        chk("lit_b_creq_low", int'(bus.change_req), 0);

        // ceiling
        rst(); c2(); c2(); c2(); c2(); c1();
        chk("lit_c_credit9", int'(bus.credit), 9);
        c2();
        chk("lit_c_reject", int'(bus.coin_reject), 1);
        chk("lit_c_credit9b", int'(bus.credit), 9);
        rst(); c2(); c2(); c2(); c1();
        cyc(1, 1, 0, 2'd0, 0, 0, 0, 0);
        chk("lit_c_both_credit", int'(bus.credit), 9);
        chk("lit_c_both_reject", int'(bus.coin_reject), 1);
        idle();
        chk("lit_c_reject_pulse", int'(bus.coin_reject), 0);

        // short selection
        rst(); c2(); c1();
        sel(2'd3);
        chk("lit_d_short", int'(bus.sel_short), 1);
        chk("lit_d_credit3", int'(bus.credit), 3);
        chk("lit_d_state", int'(bus.state), 1);

        // dispense timeout, then reset mid-change
        rst(); c2(); c2(); c2(); c1();
        sel(2'd3);
        chk("lit_e_vend", int'(bus.state), 2);
        for (int i = 0; i < TMO - 1; i++) idle();
        chk("lit_e_still_vend", int'(bus.state), 2);
        chk("lit_e_no_fault", int'(bus.fault), 0);
        idle();
        chk("lit_e_fault", int'(bus.fault), 1);
        chk("lit_e_credit7", int'(bus.credit), 7);
        chk("lit_e_change", int'(bus.state), 3);
        ack(); ack(); ack();
        chk("lit_f_credit4", int'(bus.credit), 4);
        rst();
        chk("lit_f_state", int'(bus.state), 0);
        chk("lit_f_credit", int'(bus.credit), 0);
        chk("lit_f_creq", int'(bus.change_req), 0);

        // randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            bus.rupee_one  = ($urandom_range(99) < 25);
            bus.rupee_two  = ($urandom_range(99) < 20);
            bus.sel_valid  = ($urandom_range(99) < 12);
            bus.sel_item   = 2'($urandom_range(3));
            bus.cancel     = ($urandom_range(99) < 4);
            bus.disp_done  = ($urandom_range(99) < 8);
            bus.change_ack = ($urandom_range(99) < 50);
            reset          = ($urandom_range(999) < 8);
        end
        @(negedge clk);
        reset = 0;
        repeat (2) @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
